// File: rtl/tl_pkg.sv
// Shared types and lamp encodings for the N-phase traffic controller.
package tl_pkg;

  typedef enum logic [2:0] {
    LEFT,
    GREEN,
    YELLOW,
    ALLRED,
    HOLD
  } state_e;

  localparam logic [3:0] L_LEFT   = 4'b1001;
  localparam logic [3:0] L_GREEN  = 4'b0100;
  localparam logic [3:0] L_YELLOW = 4'b0010;
  localparam logic [3:0] L_RED    = 4'b0001;

endpackage

// File: rtl/tl_interval_timer.sv
// Interval counter: counts 0..dur-1, pulses done on the last count, cleared by the FSM.
module tl_interval_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == dur_i - CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection controller: left/green/yellow/all-red rotation with
// directed emergency preemption that always clears through yellow and all-red.
module traffic_phase_ctrl
  import tl_pkg::*;
#(
  parameter int N_PHASES = 2,
  parameter int CNT_W    = 5,
  parameter int LEFT_T   = 4,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PW       = $clog2(N_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  emergency,
  input  logic [PW-1:0]         emg_phase,
  output logic [4*N_PHASES-1:0] lights,
  output logic [PW-1:0]         active_phase,
  output logic                  preempt_active
);

  localparam logic [PW-1:0] LAST = PW'(N_PHASES - 1);

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  state_e                         state_q, state_d;
  logic [PW-1:0]                  active_q, active_d;
  logic [PW-1:0]                  target_q, target_d;
  logic                           preempt_q, preempt_d;
  logic                           leave_q, leave_d;   // set once HOLD is released
  logic [CNT_W-1:0]               dur;
  logic                           done, clear, entry, tgt_ok;
  logic [N_PHASES-1:0][3:0]       lamp;

  assign tgt_ok = int'(target_q) < N_PHASES;

  always_comb begin
    dur = CNT_W'(ALLRED_T);
    case (state_q)
      LEFT:    dur = CNT_W'(LEFT_T);
      GREEN:   dur = CNT_W'(GREEN_T);
      YELLOW:  dur = CNT_W'(YELLOW_T);
      default: dur = CNT_W'(ALLRED_T);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    target_d  = target_q;
    preempt_d = preempt_q;
    leave_d   = leave_q;
    entry     = emergency && !preempt_q;
    if (entry) begin
      preempt_d = 1'b1;
      target_d  = emg_phase;
    end
    case (state_q)
      LEFT, GREEN: begin
        if (entry)     state_d = (emg_phase == active_q) ? HOLD : YELLOW;
        else if (done) state_d = (state_q == LEFT) ? GREEN : YELLOW;
      end
      YELLOW: if (done) state_d = ALLRED;
      ALLRED: begin
        if (done) begin
          // Clearance done: either park in HOLD or resume the rotation.
          if (preempt_d && !leave_q) begin
            state_d = HOLD;
            if (int'(target_d) < N_PHASES) active_d = target_d;
          end else begin
            state_d   = (LEFT_T == 0) ? GREEN : LEFT;
            active_d  = inc_wrap(active_q);
            preempt_d = 1'b0;
            leave_d   = 1'b0;
          end
        end
      end
      HOLD: begin
        if (!emergency) begin
          leave_d = 1'b1;
          state_d = tgt_ok ? YELLOW : ALLRED;
        end
      end
      default: state_d = ALLRED;
    endcase
  end

  assign clear = (state_d != state_q) || (state_q == HOLD);

  tl_interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .dur_i   (dur),
    .done_o  (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ALLRED;
      active_q  <= LAST;
      target_q  <= '0;
      preempt_q <= 1'b0;
      leave_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      target_q  <= target_d;
      preempt_q <= preempt_d;
      leave_q   <= leave_d;
    end
  end

  for (genvar p = 0; p < N_PHASES; p++) begin : g_lamp
    assign lamp[p] =
      (state_q == HOLD)      ? ((tgt_ok && target_q == PW'(p)) ? L_GREEN : L_RED) :
      (active_q != PW'(p))   ? L_RED    :
      (state_q == LEFT)      ? L_LEFT   :
      (state_q == GREEN)     ? L_GREEN  :
      (state_q == YELLOW)    ? L_YELLOW : L_RED;
  end

  assign lights         = lamp;
  assign active_phase   = active_q;
  assign preempt_active = preempt_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench: two controllers (2-phase defaults, 3-phase no-left) against an interval-queue model.
module tb_traffic_phase_ctrl;

  localparam int K_L = 0, K_G = 1, K_Y = 2, K_R = 3, K_H = 4;
  localparam int GT = 10, YT = 3, RT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic emgA = 1'b0, emgB = 1'b0;
  logic epA = 1'b0;
  logic [1:0] epB = 2'd0;
  logic [7:0] lA;
  logic [11:0] lB;
  logic actA, preA, preB;
  logic [1:0] actB;

  int n_cmp = 0, n_fail = 0;
  int j = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut_a (
    .clk(clk), .rst(rst), .emergency(emgA), .emg_phase(epA),
    .lights(lA), .active_phase(actA), .preempt_active(preA)
  );

  traffic_phase_ctrl #(.N_PHASES(3), .LEFT_T(0)) dut_b (
    .clk(clk), .rst(rst), .emergency(emgB), .emg_phase(epB),
    .lights(lB), .active_phase(actB), .preempt_active(preB)
  );

  // Model: each controller is a queue of lamp intervals still to be shown.
  typedef struct {int kind; int ph; int rem;} seg_t;
  seg_t mq[2][8];
  int mc[2];
  int PN[2] = '{2, 3};
  int PL[2] = '{4, 0};
  int m_act[2], m_pre[2], m_tgt[2], m_nxt[2];

  function automatic void push(input int i, input int k, input int ph, input int rem);
    mq[i][mc[i]].kind = k;
    mq[i][mc[i]].ph   = ph;
    mq[i][mc[i]].rem  = rem;
    mc[i]++;
  endfunction

  function automatic void pop(input int i);
    for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
    mc[i]--;
  endfunction

  function automatic void start_head(input int i);
    if (mc[i] == 0) begin
      if (PL[i] > 0) push(i, K_L, m_nxt[i], PL[i]);
      push(i, K_G, m_nxt[i], GT);
      push(i, K_Y, m_nxt[i], YT);
      push(i, K_R, m_nxt[i], RT);
      m_nxt[i] = (m_nxt[i] + 1) % PN[i];
    end
    if (mq[i][0].kind == K_L || mq[i][0].kind == K_G) begin
      m_pre[i] = 0;
      m_act[i] = mq[i][0].ph;
    end else if (mq[i][0].kind == K_H && m_tgt[i] < PN[i]) begin
      m_act[i] = m_tgt[i];
    end
  endfunction

  function automatic void m_reset(input int i);
    mc[i] = 0;
    push(i, K_R, 0, RT);
    m_act[i] = PN[i] - 1;
    m_pre[i] = 0;
    m_tgt[i] = 0;
    m_nxt[i] = 0;
  endfunction

  function automatic void m_step(input int i, input bit emg, input int ep);
    int k;
    int ph;
    k = mq[i][0].kind;
    if (k == K_H) begin
      if (!emg) begin
        mc[i] = 0;
        if (m_tgt[i] < PN[i]) begin
          push(i, K_Y, m_tgt[i], YT);
          push(i, K_R, m_tgt[i], RT);
          m_nxt[i] = (m_tgt[i] + 1) % PN[i];
        end else begin
          push(i, K_R, m_act[i], RT);
          m_nxt[i] = (m_act[i] + 1) % PN[i];
        end
        start_head(i);
      end
      return;
    end
    if (emg && m_pre[i] == 0) begin
      m_pre[i] = 1;
      m_tgt[i] = ep;
      if (k == K_L || k == K_G) begin
        ph = mq[i][0].ph;
        mc[i] = 0;
        if (ep != ph) begin
          push(i, K_Y, ph, YT);
          push(i, K_R, ph, RT);
        end
        push(i, K_H, ep, 0);
        start_head(i);
        return;
      end
      mc[i] = (k == K_Y) ? 2 : 1;
      push(i, K_H, ep, 0);
    end
    mq[i][0].rem--;
    if (mq[i][0].rem == 0) begin
      pop(i);
      start_head(i);
    end
  endfunction

  function automatic logic [11:0] exp_lights(input int i);
    logic [11:0] v;
    logic [3:0] nib;
    v = '0;
    for (int p = 0; p < PN[i]; p++) begin
      nib = 4'b0001;
      if (mq[i][0].kind == K_H) begin
        if (p == m_tgt[i]) nib = 4'b0100;
      end else if (p == mq[i][0].ph) begin
        case (mq[i][0].kind)
          K_L: nib = 4'b1001;
          K_G: nib = 4'b0100;
          K_Y: nib = 4'b0010;
          default: nib = 4'b0001;
        endcase
      end
      v[4*p +: 4] = nib;
    end
    return v;
  endfunction

  initial begin
    m_reset(0);
    m_reset(1);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset(0);
        m_reset(1);
      end else begin
        m_step(0, emgA, int'(epA));
        m_step(1, emgB, int'(epB));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @j=%0d: got %0h expected %0h", nm, j, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("A.lights", lA, exp_lights(0));
        chk("A.active", actA, m_act[0]);
        chk("A.preempt", preA, m_pre[0]);
        chk("B.lights", lB, exp_lights(1));
        chk("B.active", actB, m_act[1]);
        chk("B.preempt", preB, m_pre[1]);
      end
    end
  end

  task automatic adv(input int t);
    while (j < t) begin
      @(negedge clk);
      j++;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst A.lights", lA, 32'h11);
    chk("rst A.active", actA, 1);
    chk("rst A.preempt", preA, 0);
    chk("rst B.lights", lB, 32'h111);
    chk("rst B.active", actB, 2);
    rst = 1'b0;
    j = 0;

    // Normal rotation
    adv(1);  chk("A left0 start", lA, 32'h19); chk("A act0", actA, 0); chk("B green0", lB, 32'h114);
    adv(4);  chk("A left0 end", lA, 32'h19);
    adv(5);  chk("A green0 start", lA, 32'h14);
    adv(14); chk("A green0 end", lA, 32'h14);
    adv(15); chk("A yellow0", lA, 32'h12); chk("B green1", lB, 32'h141); chk("B act1", actB, 1);
    adv(18); chk("A allred", lA, 32'h11);
    adv(19); chk("A left1 at +18", lA, 32'h91); chk("A act1", actA, 1);
    adv(29); chk("B green2", lB, 32'h411);
    adv(37); chk("A period 36", lA, 32'h19);
    adv(43); chk("B wrap to 0", lB, 32'h114);

    // Directed preemption of phase 1 in cycle 5 of phase 0 green
    adv(45); emgA = 1'b1; epA = 1'b1;
    adv(46); chk("A pre yellow", lA, 32'h12); chk("A pre flag", preA, 1); chk("A pre act", actA, 0);
    adv(49); chk("A pre allred", lA, 32'h11);
    adv(50); chk("A hold p1", lA, 32'h41); chk("A hold act", actA, 1);
    adv(55); chk("A hold held", lA, 32'h41); emgA = 1'b0;
    adv(56); chk("A exit yellow1", lA, 32'h21);
    adv(59); chk("A exit allred", lA, 32'h11); chk("A exit flag", preA, 1);
    adv(60); chk("A resume left0", lA, 32'h19); chk("A resume flag", preA, 0);
    emgB = 1'b1; epB = 2'd3;
    adv(61); chk("B stop yellow1", lB, 32'h121); chk("B stop flag", preB, 1);
    adv(64); chk("B stop allred", lB, 32'h111);
    adv(65); chk("B hold allstop", lB, 32'h111); chk("B hold act", actB, 1);

    // Emergency for the phase already in green
    adv(66); emgA = 1'b1; epA = 1'b0;
    adv(67); chk("A hold same", lA, 32'h14); chk("A hold same flag", preA, 1);
    emgB = 1'b0;
    adv(68); chk("B release allred", lB, 32'h111);
    adv(69); chk("A hold same 2", lA, 32'h14); emgA = 1'b0;
    chk("B resume green2", lB, 32'h411); chk("B resume act", actB, 2); chk("B resume flag", preB, 0);
    adv(70); chk("A same yellow", lA, 32'h12);
    adv(73); chk("A same allred", lA, 32'h11);
    adv(74); chk("A next left1", lA, 32'h91); chk("A next flag", preA, 0);

    // One-cycle all-stop pulse during yellow
    adv(93); chk("B yellow0", lB, 32'h112); emgB = 1'b1; epB = 2'd3;
    adv(94); emgB = 1'b0; chk("B pulse yellow", lB, 32'h112); chk("B pulse flag", preB, 1);
    adv(96); chk("B pulse allred", lB, 32'h111);
    adv(97); chk("B pulse hold", lB, 32'h111); chk("B pulse hold act", actB, 0);
    adv(98); chk("B pulse exit allred", lB, 32'h111);
    adv(99); chk("B pulse resume", lB, 32'h141); chk("B pulse resume act", actB, 1);

    // Asynchronous reset mid-green
    adv(100); chk("A mid green", lA, 32'h14);
    #2 rst = 1'b1;
    #1 chk("async A.lights", lA, 32'h11); chk("async A.active", actA, 1);
    chk("async B.lights", lB, 32'h111); chk("async B.active", actB, 2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    j = 0;
    adv(1);  chk("rerun A left0", lA, 32'h19); chk("rerun B green0", lB, 32'h114);
    adv(5);  chk("rerun A green0", lA, 32'h14);
    adv(19); chk("rerun A left1", lA, 32'h91);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
